// File: rtl/channel_readout_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : channel_readout_arbiter
//  Description : Round-robin arbiter granting one of NUMCHANNELS ADC channels
//                access to the shared event-FIFO write port. The winning
//                channel's word is packed with its ID and a timestamp, offered
//                with valid/ready, and the channel is acked once accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_readout_arbiter #(
    parameter int NUMCHANNELS = 64,
    parameter int ADCBITS     = 8,
    parameter int TS_W        = 24,
    parameter int CHAN_W      = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              arb_enable,
    input  logic [NUMCHANNELS-1:0]            channel_mask,
    input  logic [NUMCHANNELS-1:0]            chan_req,
    input  logic [NUMCHANNELS*ADCBITS-1:0]    chan_data,
    output logic [NUMCHANNELS-1:0]            chan_ack,
    output logic                              fifo_wr_valid,
    input  logic                              fifo_wr_ready,
    output logic [CHAN_W+ADCBITS+TS_W-1:0]    fifo_wr_data,
    output logic [TS_W-1:0]                   timestamp,
    output logic                              busy
);

    localparam int                      c_DATA_W   = CHAN_W + ADCBITS + TS_W;
    localparam logic [CHAN_W:0]         c_NCH_EXT  = (CHAN_W+1)'(NUMCHANNELS);
    localparam logic [CHAN_W-1:0]       c_LAST_CH  = CHAN_W'(NUMCHANNELS-1);
    localparam logic [NUMCHANNELS-1:0]  c_ONE_HOT0 = NUMCHANNELS'(1);

    typedef enum logic [0:0] {
        c_ST_IDLE  = 1'b0,
        c_ST_OFFER = 1'b1
    } state_t;

    state_t                   r_state;
    logic [CHAN_W-1:0]        r_rr_ptr;
    logic [NUMCHANNELS-1:0]   r_ack;
    logic                     r_valid;
    logic [c_DATA_W-1:0]      r_data;
    logic [TS_W-1:0]          r_ts;

    logic [NUMCHANNELS-1:0]   w_elig;
    logic                     w_found;
    logic [CHAN_W-1:0]        w_sel;
    logic [CHAN_W:0]          w_cand;
    logic [ADCBITS-1:0]       w_adc;
    logic [CHAN_W-1:0]        w_cur_id;

    // A channel acked this cycle is excluded so it cannot win again before it drops its request
    assign w_elig   = chan_req & ~channel_mask & ~r_ack;
    assign w_cur_id = r_data[c_DATA_W-1 -: CHAN_W];
    assign w_adc    = chan_data[int'(w_sel)*ADCBITS +: ADCBITS];

    // Search upward from rr_ptr with wrap; first eligible channel found wins
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUMCHANNELS; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (CHAN_W+1)'(i);
            if (w_cand >= c_NCH_EXT) begin
                w_cand = w_cand - c_NCH_EXT;
            end
            if (!w_found && w_elig[w_cand[CHAN_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[CHAN_W-1:0];
            end
        end
    end

    // Free-running timestamp, independent of arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Grant / offer FSM; packet is frozen while offered and the ack follows acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_ack    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (arb_enable && w_found) begin
                        r_data  <= {w_sel, w_adc, r_ts};
                        r_valid <= 1'b1;
                        r_state <= c_ST_OFFER;
                    end
                end
                c_ST_OFFER: begin
                    if (fifo_wr_ready) begin
                        r_valid  <= 1'b0;
                        r_ack    <= c_ONE_HOT0 << w_cur_id;
                        r_rr_ptr <= (w_cur_id == c_LAST_CH) ? '0 : w_cur_id + 1'b1;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign chan_ack      = r_ack;
    assign fifo_wr_valid = r_valid;
    assign fifo_wr_data  = r_data;
    assign timestamp     = r_ts;
    assign busy          = (r_state == c_ST_OFFER);

endmodule
`default_nettype wire

// File: tb/tb_channel_readout_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_readout_arbiter
//  Description : Self-checking bench for channel_readout_arbiter: directed
//                vector table, multi-cycle corner sequences and a randomized
//                run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_readout_arbiter;

    localparam int N  = 64;
    localparam int AB = 8;
    localparam int TW = 12;
    localparam int CW = 6;
    localparam int DW = CW + AB + TW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arb_enable = 1'b0;
    logic [N-1:0]    channel_mask = '0;
    logic [N-1:0]    chan_req = '0;
    logic [N*AB-1:0] chan_data = '0;
    logic [N-1:0]    chan_ack;
    logic            fifo_wr_valid;
    logic            fifo_wr_ready = 1'b0;
    logic [DW-1:0]   fifo_wr_data;
    logic [TW-1:0]   timestamp;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    channel_readout_arbiter #(
        .NUMCHANNELS (N),
        .ADCBITS     (AB),
        .TS_W        (TW),
        .CHAN_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arb_enable    (arb_enable),
        .channel_mask  (channel_mask),
        .chan_req      (chan_req),
        .chan_data     (chan_data),
        .chan_ack      (chan_ack),
        .fifo_wr_valid (fifo_wr_valid),
        .fifo_wr_ready (fifo_wr_ready),
        .fifo_wr_data  (fifo_wr_data),
        .timestamp     (timestamp),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    logic          m_valid;
    logic [CW-1:0] m_id;
    logic [AB-1:0] m_adc;
    logic [TW-1:0] m_ts;
    logic [TW-1:0] m_tsg;
    logic [N-1:0]  m_ack;
    int            m_ptr;
    int            m_pick;

    // Round-robin choice: first requesting channel at or after ptr, else the lowest one
    function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
        int cands[$];
        for (int k = 0; k < N; k++) if (elig[k]) cands.push_back(k);
        if (cands.size() == 0) return -1;
        foreach (cands[i]) if (cands[i] >= ptr) return cands[i];
        return cands[0];
    endfunction

    always_comb m_pick = rr_pick(chan_req & ~channel_mask & ~m_ack, m_ptr);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_id    <= '0;
            m_adc   <= '0;
            m_ts    <= '0;
            m_tsg   <= '0;
            m_ack   <= '0;
            m_ptr   <= 0;
        end else begin
            m_ts  <= m_ts + 1'b1;
            m_ack <= '0;
            if (m_valid) begin
                if (fifo_wr_ready) begin
                    m_valid <= 1'b0;
                    m_ack   <= 64'd1 << m_id;
                    m_ptr   <= (int'(m_id) + 1) % N;
                end
            end else if (arb_enable && m_pick >= 0) begin
                m_valid <= 1'b1;
                m_id    <= CW'(m_pick);
                m_adc   <= chan_data[m_pick*AB +: AB];
                m_tsg   <= m_ts;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AB-1:0] pat(input int k);
        return (k == 5) ? 8'hA7 : AB'(k * 3 + 1);
    endfunction

    task automatic load_pattern();
        for (int k = 0; k < N; k++) chan_data[k*AB +: AB] = pat(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        arb_enable = 1'b0; chan_req = '0; channel_mask = '0; fifo_wr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_model();
        chk("m_valid", 64'(fifo_wr_valid), 64'(m_valid));
        chk("m_ack",   chan_ack, m_ack);
        chk("m_busy",  64'(busy), 64'(m_valid));
        chk("m_ts",    64'(timestamp), 64'(m_ts));
        if (m_valid) chk("m_data", 64'(fifo_wr_data), 64'({m_id, m_adc, m_tsg}));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [N-1:0]  req;
        logic [N-1:0]  mask;
        logic          en;
        logic          ready;
        logic          ev;
        logic [CW-1:0] eid;
        logic [N-1:0]  eack;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic          prev_v;
        logic [TW-1:0] pre_ts;
        logic [TW-1:0] exp_ts;
        logic [DW-1:0] exp_d;

        tbl[0]  = '{64'h20, 64'h0, 1'b1, 1'b1, 1'b1, 6'd5, 64'h0};
        tbl[1]  = '{64'h20, 64'h0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h20};
        tbl[2]  = '{64'h0,  64'h0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[3]  = '{64'h81, 64'h0, 1'b1, 1'b1, 1'b1, 6'd7, 64'h0};
        tbl[4]  = '{64'h81, 64'h0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h80};
        tbl[5]  = '{64'h81, 64'h0, 1'b1, 1'b1, 1'b1, 6'd0, 64'h0};
        tbl[6]  = '{64'h81, 64'h0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h1};
        tbl[7]  = '{64'h80, 64'h0, 1'b1, 1'b1, 1'b1, 6'd7, 64'h0};
        tbl[8]  = '{64'h0,  '1,    1'b0, 1'b0, 1'b1, 6'd7, 64'h0};
        tbl[9]  = '{64'h0,  '1,    1'b0, 1'b0, 1'b1, 6'd7, 64'h0};
        tbl[10] = '{64'h0,  '1,    1'b0, 1'b1, 1'b0, 6'd0, 64'h80};
        tbl[11] = '{64'h8,  64'h0, 1'b0, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[12] = '{64'h8,  64'h0, 1'b1, 1'b1, 1'b1, 6'd3, 64'h0};
        tbl[13] = '{64'h0,  64'h0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h8};

        // Reset state
        load_pattern();
        do_reset();
        #1;
        chk("rst_valid", 64'(fifo_wr_valid), 64'd0);
        chk("rst_ack",   chan_ack, 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_data",  64'(fifo_wr_data), 64'd0);
        chk("rst_ts",    64'(timestamp), 64'd0);

        // Directed table
        prev_v = 1'b0;
        exp_ts = '0;
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            chan_req = tbl[r].req; channel_mask = tbl[r].mask;
            arb_enable = tbl[r].en; fifo_wr_ready = tbl[r].ready;
            pre_ts = m_ts;
            step();
            if (tbl[r].ev && !prev_v) exp_ts = pre_ts;
            chk($sformatf("tbl%0d_valid", r), 64'(fifo_wr_valid), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_busy", r),  64'(busy), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_ack", r),   chan_ack, tbl[r].eack);
            if (tbl[r].ev) begin
                chk($sformatf("tbl%0d_id", r),  64'(fifo_wr_data[DW-1 -: CW]), 64'(tbl[r].eid));
                chk($sformatf("tbl%0d_adc", r), 64'(fifo_wr_data[TW +: AB]), 64'(pat(int'(tbl[r].eid))));
                chk($sformatf("tbl%0d_tsf", r), 64'(fifo_wr_data[TW-1:0]), 64'(exp_ts));
            end
            prev_v = tbl[r].ev;
        end

        // All channels requesting: strict order 0..63,0 at one packet per two cycles
        do_reset();
        @(negedge clk);
        chan_req = '1; arb_enable = 1'b1; fifo_wr_ready = 1'b1;
        for (int n = 0; n < N + 1; n++) begin
            step();
            chk("rr_valid", 64'(fifo_wr_valid), 64'd1);
            chk("rr_id",    64'(fifo_wr_data[DW-1 -: CW]), 64'(n % N));
            step();
            chk("rr_vlow",  64'(fifo_wr_valid), 64'd0);
            chk("rr_ack",   chan_ack, 64'd1 << (n % N));
        end

        // Stall: ready low 20 cycles while request drops and data churns
        do_reset();
        load_pattern();
        @(negedge clk);
        chan_req = 64'd1 << 10; arb_enable = 1'b1; fifo_wr_ready = 1'b0;
        exp_d = {6'd10, pat(10), m_ts};
        step();
        chk("stall_grant", 64'(fifo_wr_valid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chan_req = '0;
            for (int k = 0; k < N; k++) chan_data[k*AB +: AB] = AB'($urandom);
            step();
            chk("stall_valid", 64'(fifo_wr_valid), 64'd1);
            chk("stall_data",  64'(fifo_wr_data), 64'(exp_d));
        end
        @(negedge clk);
        fifo_wr_ready = 1'b1;
        step();
        chk("stall_done", 64'(fifo_wr_valid), 64'd0);
        chk("stall_ack",  chan_ack, 64'd1 << 10);
        load_pattern();

        // Pointer at 63, only channel 0 requests: wrap grant; then masked: nothing
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            @(negedge clk);
            chan_req = 64'd1 << 62; arb_enable = 1'b1; fifo_wr_ready = 1'b1;
            step();
            chk("p62_id", 64'(fifo_wr_data[DW-1 -: CW]), 64'd62);
            step();
            chk("p62_ack", chan_ack, 64'd1 << 62);
            @(negedge clk);
            chan_req = 64'd1;
            channel_mask = (pass == 1) ? 64'd1 : 64'd0;
            if (pass == 0) begin
                step();
                chk("wrap_valid", 64'(fifo_wr_valid), 64'd1);
                chk("wrap_id",    64'(fifo_wr_data[DW-1 -: CW]), 64'd0);
            end else begin
                for (int c = 0; c < 10; c++) begin
                    step();
                    chk("mask_valid", 64'(fifo_wr_valid), 64'd0);
                    chk("mask_busy",  64'(busy), 64'd0);
                end
            end
        end

        // Asynchronous reset during OFFER, then re-grant from pointer 0
        do_reset();
        @(negedge clk);
        chan_req = 64'd1 << 10; arb_enable = 1'b1; fifo_wr_ready = 1'b1;
        step();
        step();
        chk("ar_ack10", chan_ack, 64'd1 << 10);
        @(negedge clk);
        chan_req = (64'd1 << 2) | (64'd1 << 40); fifo_wr_ready = 1'b0;
        step();
        chk("ar_id40", 64'(fifo_wr_data[DW-1 -: CW]), 64'd40);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(fifo_wr_valid), 64'd0);
        chk("ar_ack",   chan_ack, 64'd0);
        chk("ar_busy",  64'(busy), 64'd0);
        chk("ar_ts",    64'(timestamp), 64'd0);
        @(negedge clk);
        reset = 1'b0; fifo_wr_ready = 1'b1;
        step();
        chk("ar_regrant_v",  64'(fifo_wr_valid), 64'd1);
        chk("ar_regrant_id", 64'(fifo_wr_data[DW-1 -: CW]), 64'd2);

        // Timestamp wrap; a packet granted in the wrap cycle carries 0
        do_reset();
        for (int i = 0; i < 5000 && m_ts != '1; i++) step();
        chk("wrap_top", 64'(timestamp), 64'((1 << TW) - 1));
        step();
        chk("wrap_zero", 64'(timestamp), 64'd0);
        @(negedge clk);
        chan_req = 64'd1 << 9; arb_enable = 1'b1; fifo_wr_ready = 1'b0;
        step();
        chk("wrap_pkt_v",  64'(fifo_wr_valid), 64'd1);
        chk("wrap_pkt_ts", 64'(fifo_wr_data[TW-1:0]), 64'd0);
        chk("wrap_next",   64'(timestamp), 64'd1);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chan_req      = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            channel_mask  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            arb_enable    = ($urandom_range(0, 9) < 8);
            fifo_wr_ready = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < N; k++) chan_data[k*AB +: AB] = AB'($urandom);
            step();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/channel_readout_arbiter.md
Name: channel_readout_arbiter

Overview:
- Round-robin arbiter that shares the single event-FIFO write port among the NUMCHANNELS digitizing channels.
- Each channel raises a request when its ADC word is ready. The arbiter picks one channel, latches its ADC word with channel ID and timestamp, and offers the packet to the FIFO with a valid/ready handshake.
- It then acknowledges the winning channel so that channel can clear and re-arm.
- Sits between the per-channel ADC/discriminator control and the shared FIFO/packet builder in the digital core.

Parameters:
- NUMCHANNELS, 64, number of requesting channels.
- ADCBITS, 8, ADC word width per channel.
- TS_W, 24, timestamp counter width.
- CHAN_W, 6, channel ID width. Must equal clog2(NUMCHANNELS).

Ports:
- clk  input  1  master clock; all logic on rising edge.
- reset  input  1  asynchronous reset, active-high.
- arb_enable  input  1  high allows new grants.
- channel_mask  input  NUMCHANNELS  1 = channel excluded from arbitration.
- chan_req  input  NUMCHANNELS  level request per channel, held until acked.
- chan_data  input  NUMCHANNELS*ADCBITS  ADC words; channel k occupies bits [k*ADCBITS +: ADCBITS].
- chan_ack  output  NUMCHANNELS  one-hot, one-cycle acknowledge.
- fifo_wr_valid  output  1  packet offered.
- fifo_wr_ready  input  1  FIFO accepts when high together with valid.
- fifo_wr_data  output  CHAN_W+ADCBITS+TS_W  {chan_id, adc_word, timestamp}, chan_id in the MSBs.
- timestamp  output  TS_W  free-running counter.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - FSM goes to IDLE.
  - rr_ptr = 0, timestamp = 0.
  - chan_ack, fifo_wr_valid, fifo_wr_data and busy are all 0.
  - Any in-flight packet is discarded and not acked.
- timestamp increments by 1 every clk and wraps from 2^TS_W-1 to 0. It does not depend on arb_enable.
- Eligible set = chan_req & ~channel_mask & ~chan_ack. Masking chan_ack prevents a just-acked channel from being re-granted before it drops its request.
- FSM states: IDLE, OFFER.
- IDLE:
  - If arb_enable = 1 and the eligible set is non-zero, select the lowest eligible index ≥ rr_ptr, wrapping to index 0 if none is found.
  - On the next edge, latch chan_id, chan_data[chan_id] and the current timestamp value into fifo_wr_data.
  - Set fifo_wr_valid = 1 and go to OFFER.
  - Grant latency is 1 cycle from request visibility to valid.
- OFFER:
  - fifo_wr_valid and fifo_wr_data are held stable until fifo_wr_valid & fifo_wr_ready on a rising edge.
  - On that edge: clear valid, assert chan_ack[chan_id] for exactly the next cycle, set rr_ptr = (chan_id+1) mod NUMCHANNELS, and go to IDLE.
  - The earliest next grant is in that same IDLE cycle. Peak throughput is 1 packet per 2 cycles.
- Boundary cases:
  - Request dropped, mask set, or arb_enable cleared during OFFER: the latched packet still completes and the ack is still issued.
  - fifo_wr_ready held low indefinitely: stay in OFFER with no timeout and no data change.
  - rr_ptr = NUMCHANNELS-1 with only channel 0 requesting: channel 0 is granted (wrap).
  - All channels requesting continuously: grant order 0,1,…,63,0,… with no starvation.
  - arb_enable low in IDLE: no grant, and rr_ptr is unchanged.
- chan_ack is registered, never more than one bit high, and is 0 whenever fifo_wr_valid is 1.

Test Plan:
- Reset, then chan_req[5]=1 with chan_data[5]=0xA7 and fifo_wr_ready=1 → valid 1 cycle later with fifo_wr_data = {6'd5, 8'hA7, ts at grant}; chan_ack[5] pulses 1 cycle; rr_ptr=6.
- All 64 requests held high, ready=1 → grant order 0..63 then 0, one packet every 2 cycles; each ack appears exactly once per round.
- Grant channel 10, hold ready=0 for 20 cycles while chan_req[10] drops and chan_data changes → valid stays 1 and data is unchanged; accepted when ready=1; ack[10] issued.
- rr_ptr=63 (after granting 62), only chan_req[0]=1 → channel 0 granted. With channel_mask[0]=1 instead → no valid ever and busy=0.
- Assert reset during OFFER → valid, ack and busy drop asynchronously; timestamp=0; after release, the pending request is re-granted from rr_ptr=0.
- Run 2^TS_W+3 cycles → timestamp wraps to 0 and continues; a packet granted at the wrap carries 0.
